// File: rtl/key_step_capture.sv
// key_step_capture: debounces the step push-button and, once per accepted
// press, emits a one-cycle STEP together with the switch operation select
// and operand captured at that moment.
module key_step_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       KEY_N,
    input  logic [9:0] SW,
    output logic       STEP,
    output logic [1:0] OP,
    output logic [7:0] DATA,
    output logic       BUSY,
    output logic [7:0] PRESS_CNT
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HELD   = 2'd2,
        DISARM = 2'd3
    } state_t;

    logic [1:0]       sync_q;
    logic             key_p;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       press_q, press_d;
    logic             busy_q, busy_d;

    // Two-flop synchronizer on the raw key; both flops rest at "released".
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], KEY_N};
        end
    end

    assign key_p = ~sync_q[1];

    // State, debounce counter and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            op_q    <= 2'b00;
            data_q  <= 8'h00;
            press_q <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            op_q    <= op_d;
            data_q  <= data_d;
            press_q <= press_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; a press is accepted only on the ARM-to-HELD edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = 1'b0;
        op_d    = op_q;
        data_d  = data_q;
        press_d = press_q;

        case (state_q)
            IDLE: begin
                if (key_p) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (!key_p) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    step_d  = 1'b1;
                    op_d    = SW[9:8];
                    data_d  = SW[7:0];
                    press_d = press_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!key_p) begin
                    state_d = DISARM;
                    cnt_d   = '0;
                end
            end
            DISARM: begin
                if (key_p) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign STEP      = step_q;
    assign OP        = op_q;
    assign DATA      = data_q;
    assign BUSY      = busy_q;
    assign PRESS_CNT = press_q;

endmodule

// File: tb/tb_key_step_capture.sv
// Directed bench for key_step_capture with a scoreboard of expected STEP events.
module tb_key_step_capture;

    localparam int unsigned DB = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       KEY_N;
    logic [9:0] SW;
    logic       STEP;
    logic [1:0] OP;
    logic [7:0] DATA;
    logic       BUSY;
    logic [7:0] PRESS_CNT;

    key_step_capture #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (4)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .KEY_N    (KEY_N),
        .SW       (SW),
        .STEP     (STEP),
        .OP       (OP),
        .DATA     (DATA),
        .BUSY     (BUSY),
        .PRESS_CNT(PRESS_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  data;
        logic [7:0]  cnt;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    logic [7:0]  exp_cnt;
    logic        prev_step = 1'b0;
    exp_t        got;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every STEP must match the oldest expected press, in content and timing.
    always @(negedge CLK) begin
        if (STEP === 1'b1) begin
            chk("step_not_back_to_back", 32'(prev_step), 32'd0);
            tests++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_step observed=1 expected=0 at cycle %0d", cyc);
            end
            if (q.size() != 0) begin
                got = q.pop_front();
                chk("step_cycle", cyc, got.cyc);
                chk("step_op", 32'(OP), 32'(got.op));
                chk("step_data", 32'(DATA), 32'(got.data));
                chk("step_press_cnt", 32'(PRESS_CNT), 32'(got.cnt));
            end
        end
        prev_step = STEP;
    end

    // Drive the key low; if the press should be accepted, schedule its STEP.
    task automatic key_down(input bit accept);
        exp_t e;
        KEY_N = 1'b0;
        if (accept) begin
            exp_cnt = exp_cnt + 8'd1;
            e.op   = SW[9:8];
            e.data = SW[7:0];
            e.cnt  = exp_cnt;
            e.cyc  = cyc + DB + 3;
            q.push_back(e);
        end
    endtask

    task automatic press(input int hold, input bit accept);
        key_down(accept);
        repeat (hold) @(negedge CLK);
        KEY_N = 1'b1;
        repeat (DB + 8) @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_step"}, 32'(STEP), 32'd0);
        chk({tag, "_op"}, 32'(OP), 32'd0);
        chk({tag, "_data"}, 32'(DATA), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_press_cnt"}, 32'(PRESS_CNT), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_N   = 1'b0;
        KEY_N   = 1'b1;
        SW      = 10'h000;
        exp_cnt = 8'h00;
        #1;
        chk_all_zero("reset_no_clock");
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk_all_zero("after_reset");

        // Clean press with BUSY timing, then SW changes while held.
        SW = 10'h2A5;
        key_down(1'b1);
        @(negedge CLK);
        @(negedge CLK);
        chk("busy_e0p1", 32'(BUSY), 32'd0);
        @(negedge CLK);
        chk("busy_e0p2", 32'(BUSY), 32'd1);
        repeat (7) @(negedge CLK);
        SW = 10'h1FF;
        repeat (10) @(negedge CLK);
        chk("hold_op", 32'(OP), 32'h2);
        chk("hold_data", 32'(DATA), 32'hA5);
        chk("hold_queue", 32'(q.size()), 32'd0);
        KEY_N = 1'b1;
        repeat (DB + 8) @(negedge CLK);
        chk("release_busy", 32'(BUSY), 32'd0);
        chk("clean_press_cnt", 32'(PRESS_CNT), 32'd1);

        // Next press captures the new switch value.
        press(10, 1'b1);
        chk("second_op", 32'(OP), 32'h1);
        chk("second_data", 32'(DATA), 32'hFF);
        chk("second_cnt", 32'(PRESS_CNT), 32'd2);

        // Press bounce: too short to be accepted.
        SW = 10'h0C3;
        key_down(1'b0);
        repeat (3) @(negedge CLK);
        chk("bounce_busy_arm", 32'(BUSY), 32'd1);
        KEY_N = 1'b1;
        repeat (DB + 8) @(negedge CLK);
        chk("bounce_busy_idle", 32'(BUSY), 32'd0);
        chk("bounce_op", 32'(OP), 32'h1);
        chk("bounce_data", 32'(DATA), 32'hFF);
        chk("bounce_cnt", 32'(PRESS_CNT), 32'd2);

        // Release bounce: one-cycle low glitch while in DISARM.
        SW = 10'h35A;
        key_down(1'b1);
        repeat (10) @(negedge CLK);
        KEY_N = 1'b1;
        repeat (3) @(negedge CLK);
        KEY_N = 1'b0;
        @(negedge CLK);
        KEY_N = 1'b1;
        repeat (3) @(negedge CLK);
        chk("glitch_busy", 32'(BUSY), 32'd1);
        repeat (DB + 8) @(negedge CLK);
        chk("glitch_queue", 32'(q.size()), 32'd0);
        chk("glitch_busy_idle", 32'(BUSY), 32'd0);
        chk("glitch_cnt", 32'(PRESS_CNT), 32'd3);
        chk("glitch_op", 32'(OP), 32'h3);
        chk("glitch_data", 32'(DATA), 32'h5A);

        // Counter wrap after 256 presses from reset.
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N   = 1'b1;
        exp_cnt = 8'h00;
        @(negedge CLK);
        for (int i = 0; i < 256; i++) begin
            SW = 10'($urandom_range(0, 1023));
            press(10, 1'b1);
        end
        chk("wrap_cnt", 32'(PRESS_CNT), 32'h00);
        chk("wrap_queue", 32'(q.size()), 32'd0);

        // Reset mid-ARM with the key held, then a fresh debounce.
        SW = 10'h2B4;
        key_down(1'b0);
        repeat (5) @(negedge CLK);
        chk("midarm_busy", 32'(BUSY), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge CLK);
        @(negedge CLK);
        RST_N   = 1'b1;
        exp_cnt = 8'h00;
        key_down(1'b1);
        repeat (10) @(negedge CLK);
        chk("post_reset_queue", 32'(q.size()), 32'd0);
        chk("post_reset_cnt", 32'(PRESS_CNT), 32'd1);
        chk("post_reset_op", 32'(OP), 32'h2);
        chk("post_reset_data", 32'(DATA), 32'hB4);
        KEY_N = 1'b1;
        repeat (DB + 8) @(negedge CLK);
        chk("final_busy", 32'(BUSY), 32'd0);
        chk("final_queue", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
